// File: rtl/otp_pkg.sv
// Shared encodings for the OTP program/read sequencer: array-controller modes,
// response status codes, sequencer state type and address-width helper.
package otp_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_READ = 2'd1;
  localparam logic [1:0] MODE_PROG = 2'd2;

  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_FAIL    = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT = 2'd2;
  localparam logic [1:0] STAT_LOCKED  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StProg   = 2'd1,
    StVerify = 2'd2,
    StResp   = 2'd3
  } otp_state_e;

  // A single-column array still needs a 1-bit column field.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otp_prog_seq_if.sv
// Request/response handshake between a requester (master) and the OTP sequencer (slave).
interface otp_prog_seq_if #(
  parameter int unsigned A = 2,
  parameter int unsigned B = 2
);
  import otp_pkg::*;

  localparam int unsigned ADDR_WIDTH = addr_width(B);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_column;
  logic [A-1:0]          req_data;
  logic                  rsp_valid;
  logic [1:0]            rsp_status;
  logic [A-1:0]          rsp_data;

  modport master (
    output req_valid, req_write, req_column, req_data,
    input  req_ready, rsp_valid, rsp_status, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_column, req_data,
    output req_ready, rsp_valid, rsp_status, rsp_data
  );

endinterface

// File: rtl/otp_wait_timer.sv
// Wait counter for the program and read phases; expired is high on the TIMEOUT-th
// counted cycle and the count holds there until cleared.
module otp_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TIMEOUT - 1);

  logic [CntWidth-1:0] cnt_q;

  assign expired = start && (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (start && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/otp_prog_seq.sv
// OTP program/verify/read sequencer with bounded retries and per-phase timeouts.
// Optional per-column write lock enabled by defining OTP_COLUMN_LOCK_EN.
module otp_prog_seq
  import otp_pkg::*;
#(
  parameter int unsigned A         = 2,
  parameter int unsigned B         = 2,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned ADDR_WIDTH = addr_width(B)
) (
  input  logic                  clk,
  input  logic                  reset,
  otp_prog_seq_if.slave         bus,
  output logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] column,
  output logic [A-1:0]          data_in,
  input  logic                  writing_successful,
  input  logic                  read_active,
  input  logic [A-1:0]          data_out,
  output logic                  busy
);

  otp_state_e            state_q, state_d;
  logic [2:0]            attempt_q, attempt_d, attempt_inc;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [A-1:0]          data_q, data_d;
  logic [A-1:0]          sample_q, sample_d;
  logic [1:0]            stat_q, stat_d;
  logic                  accept, fail_attempt;
  logic                  timer_start, timer_clear, timer_expired;
`ifdef OTP_COLUMN_LOCK_EN
  logic [B-1:0]          lock_q;
  logic                  lock_set;
`endif

  assign accept      = bus.req_valid && bus.req_ready;
  assign attempt_inc = attempt_q + 3'd1;
  assign timer_start = (state_q == StProg) || (state_q == StVerify);

  otp_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .clear   (timer_clear),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    attempt_d    = attempt_q;
    write_d      = write_q;
    col_d        = col_q;
    data_d       = data_q;
    sample_d     = sample_q;
    stat_d       = stat_q;
    fail_attempt = 1'b0;
    timer_clear  = 1'b0;
`ifdef OTP_COLUMN_LOCK_EN
    lock_set     = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          write_d   = bus.req_write;
          col_d     = bus.req_column;
          data_d    = bus.req_data;
          attempt_d = '0;
          sample_d  = '0;
          if (!bus.req_write) begin
            state_d = StVerify;
`ifdef OTP_COLUMN_LOCK_EN
          end else if (lock_q[bus.req_column]) begin
            state_d = StResp;
            stat_d  = STAT_LOCKED;
`endif
          end else begin
            state_d = StProg;
          end
        end
      end
      StProg: begin
        // A success on the expiry cycle still counts as a successful program.
        if (writing_successful) begin
          state_d = StVerify;
        end else if (timer_expired) begin
          fail_attempt = 1'b1;
        end
      end
      StVerify: begin
        if (read_active) begin
          sample_d = data_out;
          if (!write_q || (data_out == data_q)) begin
            state_d = StResp;
            stat_d  = STAT_OK;
`ifdef OTP_COLUMN_LOCK_EN
            lock_set = write_q;
`endif
          end else begin
            fail_attempt = 1'b1;
          end
        end else if (timer_expired) begin
          if (write_q) begin
            fail_attempt = 1'b1;
          end else begin
            state_d = StResp;
            stat_d  = STAT_TIMEOUT;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fail_attempt) begin
      attempt_d = attempt_inc;
      if (32'(attempt_inc) < MAX_RETRY) begin
        // A PROG timeout retries in place, so the timer needs an explicit restart.
        state_d     = StProg;
        timer_clear = 1'b1;
      end else begin
        state_d = StResp;
        stat_d  = STAT_FAIL;
      end
    end

    if (state_d != state_q) begin
      timer_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      attempt_q <= '0;
      write_q   <= 1'b0;
      col_q     <= '0;
      data_q    <= '0;
      sample_q  <= '0;
      stat_q    <= STAT_OK;
    end else begin
      state_q   <= state_d;
      attempt_q <= attempt_d;
      write_q   <= write_d;
      col_q     <= col_d;
      data_q    <= data_d;
      sample_q  <= sample_d;
      stat_q    <= stat_d;
    end
  end

`ifdef OTP_COLUMN_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= '0;
    end else if (lock_set) begin
      lock_q[col_q] <= 1'b1;
    end
  end
`endif

  always_comb begin
    case (state_q)
      StProg:   mode = MODE_PROG;
      StVerify: mode = MODE_READ;
      default:  mode = MODE_IDLE;
    endcase
  end

  assign busy           = (state_q != StIdle);
  assign bus.req_ready  = (state_q == StIdle) && !reset;
  assign column         = busy ? col_q : '0;
  assign data_in        = busy ? data_q : '0;
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_status = bus.rsp_valid ? stat_q : STAT_OK;
  assign bus.rsp_data   = bus.rsp_valid ? sample_q : '0;

endmodule

// File: tb/tb_otp_prog_seq.sv
// Directed bench for otp_prog_seq: table of whole transactions driven through a
// reactive array-controller model, plus hand sequences for reset, idle and column lock.
module tb_otp_prog_seq;
  import otp_pkg::*;

  localparam int unsigned A = 2;
  localparam int unsigned B = 2;

  typedef struct {
    bit         wr;
    logic [0:0] col;
    logic [1:0] data;
    int         ws_at;       // PROG cycle (1-based) that sees writing_successful, 0 = never
    int         ra_at;       // VERIFY cycle (1-based) that sees read_active, 0 = never
    logic [1:0] dout;
    logic [1:0] exp_stat;
    logic [1:0] exp_data;
    int         exp_lat;     // edges from acceptance edge to the RESP cycle
    int         exp_entries; // visible entries into MODE_PROG
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [0:0] column;
  logic [1:0] data_in;
  logic       writing_successful;
  logic       read_active;
  logic [1:0] data_out;
  logic       busy;

  int checks = 0;
  int failures = 0;

  vec_t vecs [11];

  otp_prog_seq_if #(.A(A), .B(B)) bus ();

  otp_prog_seq #(
    .A         (A),
    .B         (B),
    .MAX_RETRY (3),
    .TIMEOUT   (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .mode               (mode),
    .column             (column),
    .data_in            (data_in),
    .writing_successful (writing_successful),
    .read_active        (read_active),
    .data_out           (data_out),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".mode"},       int'(mode), int'(MODE_IDLE));
    chk({tag, ".column"},     int'(column), 0);
    chk({tag, ".data_in"},    int'(data_in), 0);
    chk({tag, ".rsp_valid"},  int'(bus.rsp_valid), 0);
    chk({tag, ".rsp_status"}, int'(bus.rsp_status), 0);
    chk({tag, ".rsp_data"},   int'(bus.rsp_data), 0);
    chk({tag, ".busy"},       int'(busy), 0);
    chk({tag, ".req_ready"},  int'(bus.req_ready), 0);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int cyc, lat, entries, pulses, in_mode, bad_fields, w;
    logic [1:0] prev_mode, st, rd, mode_at_rsp;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk({tag, ".ready"}, int'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_column = v.col;
    bus.req_data   = v.data;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_column = '0;
    bus.req_data   = '0;
    cyc = 0; lat = -1; entries = 0; pulses = 0; in_mode = 0; bad_fields = 0;
    prev_mode = MODE_IDLE; st = '0; rd = '0; mode_at_rsp = '0;
    while (cyc < 300) begin
      if (mode != prev_mode) begin
        in_mode = 1;
        if (mode == MODE_PROG) entries++;
      end else begin
        in_mode++;
      end
      prev_mode          = mode;
      writing_successful = (mode == MODE_PROG) && (in_mode == v.ws_at);
      read_active        = (mode == MODE_READ) && (in_mode == v.ra_at);
      data_out           = read_active ? v.dout : ~v.dout;
      @(negedge clk);
      if (busy && (column != v.col || data_in != v.data)) bad_fields++;
      if (bus.rsp_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc; st = bus.rsp_status; rd = bus.rsp_data; mode_at_rsp = mode;
        end
      end
      if (lat >= 0 && cyc > lat) break;
      @(posedge clk); #1;
      cyc++;
    end
    writing_successful = 1'b0;
    read_active        = 1'b0;
    data_out           = '0;
    chk({tag, ".latency"},     lat, v.exp_lat);
    chk({tag, ".status"},      int'(st), int'(v.exp_stat));
    chk({tag, ".rsp_data"},    int'(rd), int'(v.exp_data));
    chk({tag, ".prog_entries"}, entries, v.exp_entries);
    chk({tag, ".rsp_pulses"},  pulses, 1);
    chk({tag, ".mode_at_rsp"}, int'(mode_at_rsp), int'(MODE_IDLE));
    chk({tag, ".busy_fields"}, bad_fields, 0);
    chk({tag, ".busy_after"},  int'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int rsp_seen;

    //            wr    col   data  ws  ra  dout  stat          rdata lat ent
    vecs[0]  = '{1'b1, 1'b1, 2'd2, 3,  1,  2'd2, STAT_OK,      2'd2, 4,  1};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 1,  2,  2'd1, STAT_OK,      2'd1, 3,  1};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 1,  1,  2'd0, STAT_FAIL,    2'd0, 6,  3};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 2,  1,  2'd1, STAT_FAIL,    2'd1, 9,  3};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 0,  0,  2'd0, STAT_TIMEOUT, 2'd0, 16, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 0,  3,  2'd3, STAT_OK,      2'd3, 3,  0};
    vecs[6]  = '{1'b0, 1'b0, 2'd0, 0,  1,  2'd2, STAT_OK,      2'd2, 1,  0};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 0,  0,  2'd0, STAT_FAIL,    2'd0, 48, 1};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 16, 1,  2'd2, STAT_OK,      2'd2, 17, 1};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 16, 1,  2'd3, STAT_FAIL,    2'd3, 51, 3};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 1,  0,  2'd1, STAT_FAIL,    2'd0, 51, 3};

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_column = '0; bus.req_data = '0;
    writing_successful = 1'b0; read_active = 1'b0; data_out = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("reset.ready_after_release", int'(bus.req_ready), 1);
    @(posedge clk); #1;

    // Array feedback in IDLE must not start anything.
    writing_successful = 1'b1; read_active = 1'b1; data_out = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ignore.busy", int'(busy), 0);
      chk("idle_ignore.rsp_valid", int'(bus.rsp_valid), 0);
      @(posedge clk); #1;
    end
    writing_successful = 1'b0; read_active = 1'b0; data_out = '0;

    for (int i = 0; i < 11; i++) begin
      apply_reset();
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a program attempt.
    apply_reset();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_column = 1'b1; bus.req_data = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_column = '0; bus.req_data = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_prog.mode_before", int'(mode), int'(MODE_PROG));
    reset = 1'b1;
    rsp_seen = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_prog");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_prog.ready_after_release", int'(bus.req_ready), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || busy) rsp_seen++;
    end
    chk("rst_prog.no_activity", rsp_seen, 0);
    @(posedge clk); #1;

    // Column lock: repeat write to column 1 after a good write.
    apply_reset();
    v = '{1'b1, 1'b1, 2'd2, 1, 1, 2'd2, STAT_OK, 2'd2, 2, 1};
    run_txn(v, "lock.first");
`ifdef OTP_COLUMN_LOCK_EN
    v = '{1'b1, 1'b1, 2'd1, 1, 1, 2'd1, STAT_LOCKED, 2'd0, 0, 0};
`else
    v = '{1'b1, 1'b1, 2'd1, 1, 1, 2'd1, STAT_OK, 2'd1, 2, 1};
`endif
    run_txn(v, "lock.repeat");
    v = '{1'b1, 1'b0, 2'd1, 1, 1, 2'd1, STAT_OK, 2'd1, 2, 1};
    run_txn(v, "lock.other_col");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
